wf_bram_fifo_ctrl: RTL
======================

# wf_bram_fifo_ctrl

Synchronous FIFO controller that turns the 256x16 BRAM macro into a 256-deep, 16-bit, first-word-fall-through stream buffer with valid/ready handshakes on both sides. It sits directly upstream of the BRAM: it owns the write and read pointers, drives the BRAM write/read ports, and absorbs the BRAM's one-cycle registered read latency with a 2-entry output buffer so that sustained throughput is one word per clock. The RAM is instantiated beside this block and wired port-to-port.

## Interface
- No parameters. Depth is fixed at 256 words and width at 16 bits to match the macro.

Ports:
- clk  in  1  single clock, rising edge; also drives the BRAM WCLK/RCLK.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  producer has a word on in_data.
- in_ready  out  1  controller accepts a word this cycle; a transfer occurs when in_valid and in_ready are both high.
- in_data  in  16  write word.
- out_valid  out  1  out_data holds the oldest word.
- out_ready  in  1  consumer takes out_data; a pop occurs when out_valid and out_ready are both high.
- out_data  out  16  head word.
- count  out  9  number of words accepted and not yet popped, 0..256.
- bram_wen  out  1  to the BRAM wen input.
- bram_waddr  out  8  to the BRAM waddr input.
- bram_wdata  out  16  to the BRAM wdata input.
- bram_ren  out  1  to the BRAM ren input. Informational only; the macro reads every cycle.
- bram_raddr  out  8  to the BRAM raddr input.
- bram_rdata  in  16  from the BRAM rdata output. Holds mem[raddr sampled at the previous edge].

## Operation
- State:
  - wr_ptr[7:0], rd_ptr[7:0];
  - mem_cnt[8:0]: words in the BRAM that have not yet been issued for read;
  - rd_inflight: a read issued last cycle;
  - buf_cnt[1:0]: 0..2 words in the output buffer, head plus skid.
- count = mem_cnt + rd_inflight + buf_cnt, registered.
- in_ready = !reset && count != 256. It has no combinational path from out_ready.
- Push:
  - bram_wen = in_valid && in_ready;
  - bram_waddr = wr_ptr; bram_wdata = in_data;
  - wr_ptr increments by 1 modulo 256 on each push.
- Read issue: rd_issue = mem_cnt != 0 && (buf_cnt + rd_inflight − pop) < 2.
  - bram_raddr = rd_ptr at all times; bram_ren = rd_issue.
  - On issue, rd_ptr increments modulo 256 and rd_inflight is set for the next cycle.
- mem_cnt next value = mem_cnt + push − rd_issue.
  - A word written at edge E is not issued before the cycle following E. This rules out same-address read-during-write on the macro.
- Output buffer:
  - When rd_inflight is high, bram_rdata is captured at the next edge into the head if the buffer is empty or is being fully drained; otherwise it goes into the skid.
  - On a pop the skid moves to the head.
  - out_valid = buf_cnt != 0.
  - out_data is stable while out_valid && !out_ready.
- Ordering is strict FIFO across pointer wrap 255→0.
- Simultaneous push and pop: both happen and count is unchanged. At count = 256, in_ready is low even if out_ready is high; the push is refused that cycle.
- Reset, at any time including mid-stream:
  - the next edge clears wr_ptr, rd_ptr, mem_cnt, rd_inflight, buf_cnt and count;
  - all queued data is discarded and BRAM contents are not cleared;
  - bram_wen is 0 during reset.

## Timing
- Reset values: in_ready 0 while reset is high and 1 the cycle after it drops; out_valid 0; out_data 0; count 0; bram_wen 0; bram_ren 0; bram_waddr 0; bram_raddr 0; bram_wdata follows in_data.
- Write latency: the word is written at the accepting edge E0.
- First-word latency into an empty FIFO:
  - read issued in the cycle after E0, with the address sampled at E1;
  - data captured at E2;
  - out_valid high in the cycle after E2.
- Throughput: with out_ready held high and a non-empty BRAM, one pop per cycle, no bubbles.
- count updates at the edge following the push or pop.

## Test plan
- Single word: after reset, push 0xA5A5 at edge E0 → bram_wen=1 with bram_waddr=0 at E0; out_valid=1 and out_data=0xA5A5 in the cycle after E2; count=1 until the pop, then 0.
- Fill: out_ready=0, push 0x0000..0x00FF → count=256 and in_ready=0 after the 256th accept; a 257th in_valid is not written (bram_wen=0); out_data=0x0000 is held stable throughout.
- Drain: from the full state, out_ready=1 → 256 pops on consecutive cycles, values 0x0000..0x00FF in order; then out_valid=0, count=0, in_ready=1.
- Streaming wrap: both sides continuous for 600 words with incrementing data → output is identical, in order and gap-free after the 3-cycle start-up; pointers wrap twice; count stays ≤ 3.
- Backpressure: random out_ready at 50% and random in_valid for 2000 words → no loss or duplication; out_data unchanged on every stalled cycle; count always equals accepted minus popped.
- Reset mid-stream: count=100, assert reset for 1 cycle → out_valid=0 and count=0 in the next cycle, in_ready=1 after release; a subsequent push of 0x1234 emerges as the first output word.

Source files
------------

// File: rtl/wf_bram_fifo_ctrl.sv
// 256x16 first-word-fall-through FIFO controller wrapped around a BRAM with one-cycle registered read.
// A two-entry head/skid buffer hides the read latency so a steady stream moves one word per clock.
module wf_bram_fifo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [8:0]  count,
  output logic        bram_wen,
  output logic [7:0]  bram_waddr,
  output logic [15:0] bram_wdata,
  output logic        bram_ren,
  output logic [7:0]  bram_raddr,
  input  logic [15:0] bram_rdata
);

  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [8:0]  mem_cnt_q, mem_cnt_d;
  logic        rd_inflight_q, rd_inflight_d;
  logic [1:0]  buf_cnt_q, buf_cnt_d;
  logic [15:0] head_q, head_d;
  logic [15:0] skid_q, skid_d;
  logic [8:0]  count_q, count_d;

  logic        push, pop, rd_issue;
  logic [2:0]  occ;
  logic [1:0]  drained;

  always_comb begin
    in_ready  = !reset && (count_q != 9'd256);
    out_valid = (buf_cnt_q != 2'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;

    // Words already committed to the buffer once this cycle's pop is taken out.
    occ      = {1'b0, buf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
    rd_issue = !reset && (mem_cnt_q != 9'd0) && (occ < 3'd2);

    wr_ptr_d      = wr_ptr_q + {7'd0, push};
    rd_ptr_d      = rd_ptr_q + {7'd0, rd_issue};
    mem_cnt_d     = mem_cnt_q + {8'd0, push} - {8'd0, rd_issue};
    rd_inflight_d = rd_issue;

    drained   = buf_cnt_q - {1'b0, pop};
    buf_cnt_d = drained + {1'b0, rd_inflight_q};
    head_d    = head_q;
    skid_d    = skid_q;
    if (pop) begin
      head_d = skid_q;
    end
    // Returning read data lands wherever the first free slot is after the pop.
    if (rd_inflight_q) begin
      if (drained == 2'd0) begin
        head_d = bram_rdata;
      end else begin
        skid_d = bram_rdata;
      end
    end

    count_d = mem_cnt_d + {8'd0, rd_inflight_d} + {7'd0, buf_cnt_d};

    out_data   = head_q;
    count      = count_q;
    bram_wen   = push;
    bram_waddr = wr_ptr_q;
    bram_wdata = in_data;
    bram_ren   = rd_issue;
    bram_raddr = rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= 8'd0;
      rd_ptr_q      <= 8'd0;
      mem_cnt_q     <= 9'd0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
      head_q        <= 16'd0;
      skid_q        <= 16'd0;
      count_q       <= 9'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_cnt_q     <= mem_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      buf_cnt_q     <= buf_cnt_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      count_q       <= count_d;
    end
  end

endmodule
